// File: rtl/counter_readout.sv
// counter_readout: snapshots Count0/Count1 on Req and streams the selected value LSB byte first.
// Optional macro READOUT_CHECKSUM_EN appends one XOR checksum byte to every frame.
module counter_readout #(
   parameter int WIDTH  = 64,
   parameter int NBYTES = WIDTH / 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Req,
   input  logic             Slt,
   input  logic [WIDTH-1:0] Count0,
   input  logic [WIDTH-1:0] Count1,
   input  logic             Ready,
   output logic [7:0]       DataOut,
   output logic             Valid,
   output logic             Last,
   output logic             Busy,
   output logic             Done
);
   localparam int IW = $clog2(NBYTES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

`ifdef READOUT_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;
   localparam logic LAST_ON_DATA = 1'b0;
`else
   typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;
   localparam logic LAST_ON_DATA = 1'b1;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] snap0_q, snap0_d, snap1_q, snap1_d;
   logic             sel_q, sel_d;
   logic [IW-1:0]    idx_q, idx_d, idx_inc;
   logic [7:0]       data_q, data_d, next_byte;
   logic             valid_q, valid_d, last_q, last_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             finish;
   logic [WIDTH-1:0] active_snap, req_count;
   logic [7:0]       snap_byte [NBYTES];
`ifdef READOUT_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   assign active_snap = sel_q ? snap1_q : snap0_q;
   assign req_count   = Slt ? Count1 : Count0;

   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign snap_byte[gi] = active_snap[8*gi +: 8];
   end

   always_comb begin
      state_d = state_q;
      snap0_d = snap0_q;
      snap1_d = snap1_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      finish  = 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      idx_inc   = idx_q + 1'b1;
      next_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx_inc == IW'(i)) next_byte = snap_byte[i];
      end

      case (state_q)
         S_IDLE: begin
            if (Req) begin
               state_d = S_SEND;
               snap0_d = Count0;
               snap1_d = Count1;
               sel_d   = Slt;
               idx_d   = '0;
               data_d  = req_count[7:0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               last_d  = LAST_ON_DATA && (LAST_IDX == '0);
`ifdef READOUT_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_SEND: begin
            if (Ready) begin
`ifdef READOUT_CHECKSUM_EN
               csum_d = csum_q ^ data_q;
`endif
               if (idx_q == LAST_IDX) begin
`ifdef READOUT_CHECKSUM_EN
                  // Checksum byte folds in the final data byte being accepted now.
                  state_d = S_CSUM;
                  data_d  = csum_q ^ data_q;
                  last_d  = 1'b1;
`else
                  finish  = 1'b1;
`endif
               end else begin
                  idx_d  = idx_inc;
                  data_d = next_byte;
                  last_d = LAST_ON_DATA && (idx_inc == LAST_IDX);
               end
            end
         end
`ifdef READOUT_CHECKSUM_EN
         S_CSUM: begin
            if (Ready) finish = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (finish) begin
         state_d = S_IDLE;
         data_d  = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         snap0_q <= '0;
         snap1_q <= '0;
         sel_q   <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         snap0_q <= snap0_d;
         snap1_q <= snap1_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef READOUT_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign DataOut = data_q;
   assign Valid   = valid_q;
   assign Last    = last_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule
